x_300_mod_503_loader: RTL and testbench
=======================================

X_300_MOD_503_LOADER -- requirements
Module: x_300_mod_503_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 30, the input beat width in bits.
REQ-002 SHALL have parameter BEATS, default 10, the maximum beats per frame; WORD_W*BEATS = 300 is fixed.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream beat is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 SHALL have port in_data, input, WORD_W bits: one operand slice, least-significant slice first.
REQ-008 SHALL have port in_last, input, 1 bit: final beat of the frame.
REQ-009 SHALL have port out_valid, output, 1 bit: the residue is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the residue.
REQ-011 SHALL have port out_r, output, 9 bits: the operand mod 503, in the range 0..502.
REQ-012 SHALL have port out_err, output, 1 bit: framing error, qualified by out_valid.

Function
REQ-013 SHALL implement a three-state FSM: COLLECT -> REDUCE -> HOLD -> COLLECT.
REQ-014 SHALL drive in_ready=1 only in COLLECT and hold it at 0 in REDUCE and HOLD; no frame overlap.
REQ-015 SHALL accept a beat when in_valid&&in_ready and write beat k (0-based) into operand bits [WORD_W*(k+1):WORD_W*k+1].
REQ-016 SHALL use a 4-bit beat counter that clears at frame end.
REQ-017 SHALL treat in_last on beat k<BEATS-1 as frame end, with all higher operand slices reading as zero (short frame).
REQ-018 SHALL end the frame on beat BEATS-1 regardless of in_last, setting the error flag if in_last=0 on that beat; the next accepted beat starts a new frame.
REQ-019 SHALL clear the operand register and error flag on entry to COLLECT, so no data from a previous frame leaks into the next.
REQ-020 SHALL enter REDUCE for exactly one cycle, capturing the combinational residue into the out_r register.
REQ-021 SHALL provide latency such that a final beat accepted at edge t raises out_valid after edge t+2 (REDUCE during cycle t+1).
REQ-022 SHALL hold out_valid with out_r and out_err stable in HOLD until out_valid&&out_ready.
REQ-023 SHALL return to COLLECT after the output handshake, with in_ready=1 from the next cycle.
REQ-024 SHALL provide a throughput of one full frame per BEATS+2 cycles with no stalls.
REQ-025 SHALL ignore in_valid outside COLLECT and shall not drop or consume beats there.
REQ-026 SHALL ignore out_ready while out_valid=0.
REQ-027 SHALL produce a residue that is exact for every 300-bit operand, with no saturation or truncation.

Reset
REQ-028 SHALL, while rst_n=0, force immediately: FSM=COLLECT, counter=0, operand=0, out_valid=0, out_r=0, out_err=0.
REQ-029 SHALL hold in_ready=0 while rst_n=0 and drive it to 1 from the first edge after rst_n releases.
REQ-030 SHALL abort any frame or held result when reset is asserted mid-operation, without emitting it.

Structure
REQ-031 SHALL place MOD=503, RES_W=9, OP_W=300 and the FSM state enum in a shared package mod_503_pkg.
REQ-032 SHALL instantiate exactly one sub-module, the existing combinational reducer x_300_mod_503 (X[300:1] -> R[9:1]), fed from the operand register.
REQ-033 SHALL contain all other logic (FSM, counter, slice write, output register) in this module.

Verification
REQ-034 SHALL pass: 1-beat frame in_data=503, in_last=1 -> out_r=0, out_err=0, out_valid 2 edges after acceptance.
REQ-035 SHALL pass: 1-beat frames in_data=502, then 512 -> out_r=502, then out_r=9 (2^9 mod 503).
REQ-036 SHALL pass: 2-beat frame {0, 1}, with 1 on beat 1 (operand=2^30) -> out_r=299.
REQ-037 SHALL pass: 10 zero beats with in_last=0 throughout -> out_r=0, out_err=1; the following 1-beat frame 5 -> out_r=5, out_err=0.
REQ-038 SHALL pass: out_ready low for 5 cycles after out_valid -> out_r and out_err stable, in_ready=0, no beats accepted; accepted on release.
REQ-039 SHALL pass: rst_n pulsed after 4 beats accepted -> out_valid=0; the next 1-beat frame 7 -> out_r=7 (no stale slices).

Source files
------------

// File: rtl/mod_503_pkg.sv
// Shared definitions for the 300-bit mod-503 loader.
// The package carries the modulus (503, prime), the residue width (0..502
// fits in 9 bits), the operand width (300 bits) and the loader FSM states.
// The helper mod_step performs one Horner step over a 9-bit chunk; since
// 2^9 mod 503 = 9, (acc*512 + chunk) mod 503 == (acc*9 + chunk) mod 503.
package mod_503_pkg;

  localparam int MOD   = 503;
  localparam int RES_W = 9;
  localparam int OP_W  = 300;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_REDUCE  = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  // acc < 503 and chunk < 512, so acc*9 + chunk <= 5029 and fits in 14 bits.
  function automatic logic [RES_W-1:0] mod_step(input logic [RES_W-1:0] acc,
                                                input logic [RES_W-1:0] chunk);
    logic [13:0] t;
    t = 14'(acc) * 14'd9 + 14'(chunk);
    return RES_W'(t % 14'(MOD));
  endfunction

endpackage

// File: rtl/x_300_mod_503_loader_if.sv
// Beat-in / residue-out bus of the mod-503 loader.
//   in_valid/in_ready/in_data/in_last : upstream beat channel
//   out_valid/out_ready/out_r/out_err : downstream residue channel
//   dbg_state                         : loader FSM state, for observation only
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready. A source holds valid and its payload stable until
// the transfer; ready may change freely and is never a function of a
// not-yet-raised valid on the same channel.
// Modports: slave = the loader, master = the upstream/downstream side.
interface x_300_mod_503_loader_if
  import mod_503_pkg::*;
  #(parameter int WORD_W = 30);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_r;
  logic              out_err;
  state_t            dbg_state;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_r, out_err, dbg_state
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_r, out_err, dbg_state
  );

endinterface

// File: rtl/x_300_mod_503.sv
// Combinational reducer: r = x mod 503 for any 300-bit x.
//   x : operand, bits [300:1] (bit 1 is the LSB)
//   r : residue, bits [9:1], always 0..502
// The operand is zero-padded to 34 chunks of 9 bits and folded MSB chunk
// first with mod_step, keeping the running value below 503 at every step,
// so the result is exact with no wide intermediate.
module x_300_mod_503
  import mod_503_pkg::*;
(
  input  logic [OP_W:1]  x,
  output logic [RES_W:1] r
);

  localparam int CHUNKS = (OP_W + RES_W - 1) / RES_W;

  logic [CHUNKS*RES_W-1:0] x_pad;
  logic [RES_W-1:0]        acc;

  always_comb begin
    x_pad = '0;
    acc   = '0;
    x_pad[OP_W-1:0] = x;
    for (int i = CHUNKS - 1; i >= 0; i--) begin
      acc = mod_step(acc, x_pad[i*RES_W +: RES_W]);
    end
    r = acc;
  end

endmodule

// File: rtl/x_300_mod_503_loader.sv
// Frame loader: collects up to BEATS slices of WORD_W bits (LSB slice first)
// into a 300-bit operand, reduces it mod 503, and presents the residue.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of x_300_mod_503_loader_if (beat in, residue out,
//                FSM state on dbg_state)
// Frame flow: COLLECT (in_ready=1) -> REDUCE (one cycle, residue captured)
// -> HOLD (out_valid=1 until out_ready) -> COLLECT.
// A frame ends on in_last or on beat BEATS-1; reaching BEATS-1 without
// in_last is flagged on out_err. The operand is zeroed when a result is
// handed off, so a short frame reads zero in its unwritten slices.
module x_300_mod_503_loader
  import mod_503_pkg::*;
#(
  parameter int WORD_W = 30,
  parameter int BEATS  = 10
) (
  input  logic clk,
  input  logic rst_n,
  x_300_mod_503_loader_if.slave bus
);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q;
  logic [OP_W-1:0]  operand_q;
  logic             err_q;
  logic [RES_W-1:0] out_r_q;
  logic             run_q;      // low during reset, high from the first edge after
  logic [RES_W-1:0] residue;

  logic in_ready_int;
  logic accept;
  logic at_last_slot;
  logic frame_end;
  logic handoff;

  x_300_mod_503 u_reducer (
    .x (operand_q),
    .r (residue)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    in_ready_int = 1'b0;
    accept       = 1'b0;
    at_last_slot = 1'b0;
    frame_end    = 1'b0;
    handoff      = 1'b0;
    state_d      = state_q;

    at_last_slot = (cnt_q == 4'(BEATS - 1));
    in_ready_int = (state_q == ST_COLLECT) && run_q;
    accept       = bus.in_valid && in_ready_int;
    frame_end    = accept && (bus.in_last || at_last_slot);
    handoff      = (state_q == ST_HOLD) && bus.out_ready;

    case (state_q)
      ST_COLLECT: if (frame_end) state_d = ST_REDUCE;
      ST_REDUCE:  state_d = ST_HOLD;
      ST_HOLD:    if (handoff) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      cnt_q     <= 4'd0;
      operand_q <= '0;
      err_q     <= 1'b0;
      out_r_q   <= '0;
    end else begin
      run_q <= 1'b1;

      if (accept) begin
        for (int k = 0; k < BEATS; k++) begin
          if (cnt_q == 4'(k)) operand_q[k*WORD_W +: WORD_W] <= bus.in_data;
        end
        if (frame_end) begin
          cnt_q <= 4'd0;
          err_q <= at_last_slot && !bus.in_last;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end

      if (state_q == ST_REDUCE) out_r_q <= residue;

      // Clearing on the way back to COLLECT keeps the previous frame out of
      // the next one's unwritten slices and drops the stale error flag.
      if (handoff) begin
        operand_q <= '0;
        err_q     <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_r     = out_r_q;
  assign bus.out_err   = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_x_300_mod_503_loader.sv
// Directed bench for x_300_mod_503_loader. Expected residues are worked out
// by hand: 2^9 = 9, 2^30 = 299, 2^251 = 1 (2 is a QR mod 503), hence
// 2^270 = 2^19 = 162 and 2^300 = 2^49 = 150, so (2^300 - 1) mod 503 = 149.
module tb_x_300_mod_503_loader;
  import mod_503_pkg::*;

  localparam int WORD_W = 30;
  localparam int BEATS  = 10;

  logic clk;
  logic rst_n;

  x_300_mod_503_loader_if #(.WORD_W(WORD_W)) bus ();

  x_300_mod_503_loader #(.WORD_W(WORD_W), .BEATS(BEATS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int fails     = 0;

  logic [RES_W-1:0] got_q[$];

  // ---------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Residues handed off downstream, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_r);
  end

  // ------------------------------------------------------------ drivers
  // Presents one beat and returns right at the rising edge that takes it.
  // in_valid is left high so consecutive calls give back-to-back beats.
  task automatic send_beat(input logic [WORD_W-1:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests_run++;
      fails++;
      $display("FAIL send_beat_timeout: in_ready=%0b after %0d cycles, want 1", bus.in_ready, n);
    end
    @(posedge clk);
  endtask

  // Called right after the final beat's edge: one REDUCE cycle, then the
  // held result, then a handshake that returns the block to COLLECT.
  task automatic check_result(input string name, input logic [RES_W-1:0] er, input logic ee);
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s_reduce: out_valid=%0b in_ready=%0b, want 0 0", name, bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_valid: out_valid=%0b, want 1", name, bus.out_valid);
    end
    tests_run++;
    if (bus.out_r !== er || bus.out_err !== ee) begin
      fails++;
      $display("FAIL %s_value: out_r=%0d out_err=%0b, want %0d %0b", name, bus.out_r, bus.out_err, er, ee);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_return: in_ready=%0b out_valid=%0b, want 1 0", name, bus.in_ready, bus.out_valid);
    end
  endtask

  // -------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_r !== 9'd0 ||
        bus.out_err !== 1'b0 || bus.dbg_state !== ST_COLLECT) begin
      fails++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b out_r=%0d out_err=%0b state=%0d, want 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_r, bus.out_err, bus.dbg_state);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_ready: in_ready=%0b before first edge, want 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_up: in_ready=%0b after first edge, want 1", bus.in_ready);
    end
  endtask

  task automatic test_single_beat();
    send_beat(30'd503, 1'b1);
    check_result("one_503", 9'd0, 1'b0);
    send_beat(30'd502, 1'b1);
    check_result("one_502", 9'd502, 1'b0);
    send_beat(30'd512, 1'b1);
    check_result("one_512", 9'd9, 1'b0);
  endtask

  task automatic test_two_beat();
    send_beat(30'd0, 1'b0);
    send_beat(30'd1, 1'b1);
    check_result("two_2pow30", 9'd299, 1'b0);
  endtask

  task automatic test_full_frame();
    // All ones across all ten slices, in_last on the last beat: no error.
    for (int k = 0; k < BEATS; k++) send_beat(30'h3FFF_FFFF, (k == BEATS - 1));
    check_result("full_ones", 9'd149, 1'b0);
    // Only the top slice set: operand = 2^270.
    for (int k = 0; k < BEATS; k++) send_beat((k == BEATS - 1) ? 30'd1 : 30'd0, (k == BEATS - 1));
    check_result("full_top", 9'd162, 1'b0);
  endtask

  task automatic test_overrun();
    for (int k = 0; k < BEATS; k++) send_beat(30'd0, 1'b0);
    check_result("overrun", 9'd0, 1'b1);
    send_beat(30'd5, 1'b1);
    check_result("after_overrun", 9'd5, 1'b0);
  endtask

  task automatic test_stall();
    send_beat(30'd100, 1'b1);
    @(negedge clk);
    // Next beat is already waiting while the result is held.
    bus.in_valid = 1'b1;
    bus.in_data  = 30'd77;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_r !== 9'd100 || bus.out_err !== 1'b0 ||
          bus.in_ready !== 1'b0 || bus.dbg_state !== ST_HOLD) begin
        fails++;
        $display("FAIL stall_hold_%0d: out_valid=%0b out_r=%0d out_err=%0b in_ready=%0b state=%0d, want 1 100 0 0 2",
                 c, bus.out_valid, bus.out_r, bus.out_err, bus.in_ready, bus.dbg_state);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: in_ready=%0b, want 1", bus.in_ready);
    end
    @(posedge clk);
    check_result("stall_next", 9'd77, 1'b0);
  endtask

  task automatic test_back_to_back();
    time t0;
    time t1;
    got_q.delete();
    bus.out_ready = 1'b1;
    send_beat(30'd1, 1'b0);
    t0 = $time;
    for (int k = 1; k < BEATS; k++) send_beat(30'd0, (k == BEATS - 1));
    send_beat(30'd0, 1'b0);
    t1 = $time;
    for (int k = 1; k < BEATS; k++) send_beat((k == BEATS - 1) ? 30'd1 : 30'd0, (k == BEATS - 1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++;
    if (t1 - t0 != 120) begin
      fails++;
      $display("FAIL b2b_period: %0t between frame starts, want 120", t1 - t0);
    end
    tests_run++;
    if (got_q.size() != 2) begin
      fails++;
      $display("FAIL b2b_count: %0d results, want 2", got_q.size());
    end else begin
      if (got_q[0] !== 9'd1 || got_q[1] !== 9'd162) begin
        fails++;
        $display("FAIL b2b_values: got %0d %0d, want 1 162", got_q[0], got_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Abort a partly collected frame.
    for (int k = 0; k < 4; k++) send_beat(30'(k + 1), 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.dbg_state !== ST_COLLECT) begin
      fails++;
      $display("FAIL reset_mid_collect: out_valid=%0b in_ready=%0b state=%0d, want 0 0 0",
               bus.out_valid, bus.in_ready, bus.dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_beat(30'd7, 1'b1);
    check_result("after_reset_collect", 9'd7, 1'b0);

    // Abort a held result.
    send_beat(30'd9, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_r !== 9'd0) begin
      fails++;
      $display("FAIL reset_mid_hold: out_valid=%0b out_r=%0d, want 0 0", bus.out_valid, bus.out_r);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_beat(30'd11, 1'b1);
    check_result("after_reset_hold", 9'd11, 1'b0);
  endtask

  // ---------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_single_beat();
    test_two_beat();
    test_full_frame();
    test_overrun();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  // Hard stop in case a driver loop is somehow never released.
  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
